// File: rtl/rom_arbiter.sv
// Two-port round-robin read arbiter for the shared synchronous ROM.
// Grants one requester, waits READ_WAIT edges, then returns the byte with a one-cycle ack.
module rom_arbiter #(
  parameter int READ_WAIT = 1,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic [ADDR_BITS-1:0] a_addr,
  output logic                 a_ack,
  output logic [7:0]           a_data,
  input  logic                 b_req,
  input  logic [ADDR_BITS-1:0] b_addr,
  output logic                 b_ack,
  output logic [7:0]           b_data,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(READ_WAIT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_b;
  logic       last_grant_b;
  logic       pick_b;

  // On a tie, B wins only if A was served last.
  assign pick_b = b_req & (~a_req | ~last_grant_b);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      gnt_b        <= 1'b0;
      last_grant_b <= 1'b1;
      rom_addr     <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_data       <= 8'h00;
      b_data       <= 8'h00;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            rom_addr     <= pick_b ? b_addr : a_addr;
            gnt_b        <= pick_b;
            last_grant_b <= pick_b;
            cnt          <= CNT_INIT;
            busy         <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (gnt_b) begin
              b_data <= rom_data;
              b_ack  <= 1'b1;
            end else begin
              a_data <= rom_data;
              a_ack  <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK: begin
          // Requests are ignored here so a requester's registered deassert is not seen as new.
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: table-driven cycle vectors plus hand-written multi-cycle sequences.
// Two instances: default READ_WAIT=1 and READ_WAIT=3, each fed by a negedge-registered ROM model.
module tb_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_req, b_req;
  logic [15:0] a_addr, b_addr;
  logic        a_ack, b_ack, busy;
  logic [7:0]  a_data, b_data, rom_data;
  logic [15:0] rom_addr;

  logic        a3_req, b3_req;
  logic [15:0] a3_addr, b3_addr;
  logic        a3_ack, b3_ack, busy3;
  logic [7:0]  a3_data, b3_data, rom_data3;
  logic [15:0] rom_addr3;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rom_arbiter #(.READ_WAIT(1), .ADDR_BITS(16)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  rom_arbiter #(.READ_WAIT(3), .ADDR_BITS(16)) dut3 (
    .clock(clock), .reset(reset),
    .a_req(a3_req), .a_addr(a3_addr), .a_ack(a3_ack), .a_data(a3_data),
    .b_req(b3_req), .b_addr(b3_addr), .b_ack(b3_ack), .b_data(b3_data),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .busy(busy3)
  );

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h1234: rom_byte = 8'hA5;
      16'h0000: rom_byte = 8'h3C;
      16'h1FFF: rom_byte = 8'hC3;
      16'h0100: rom_byte = 8'h7E;
      default:  rom_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // ROM registers its output on the falling edge.
  always @(negedge clock) begin
    rom_data  <= rom_byte(rom_addr);
    rom_data3 <= rom_byte(rom_addr3);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        a_req;
    logic [15:0] a_addr;
    logic        b_req;
    logic [15:0] b_addr;
    logic        exp_a_ack;
    logic        exp_b_ack;
    logic        exp_busy;
    logic [15:0] exp_rom_addr;
    logic [7:0]  exp_a_data;
    logic [7:0]  exp_b_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic        got;
    logic        exp_b;
    logic [15:0] next_a, next_b;

    // Simultaneous A/B from reset, then a single A read of 0x1234.
    vecs[0] = '{1'b1, 16'h0000, 1'b1, 16'h1FFF, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 16'h0000, 1'b1, 16'h1FFF, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h1FFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'h1FFF, 1'b0, 1'b0, 1'b1, 16'h1FFF, 8'h3C, 8'h00};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h1FFF, 1'b0, 1'b1, 1'b1, 16'h1FFF, 8'h3C, 8'hC3};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h1FFF, 1'b0, 1'b0, 1'b0, 16'h1FFF, 8'h3C, 8'hC3};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h1FFF, 1'b0, 1'b0, 1'b0, 16'h1FFF, 8'h3C, 8'hC3};
    vecs[7] = '{1'b1, 16'h1234, 1'b0, 16'h1FFF, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h3C, 8'hC3};
    vecs[8] = '{1'b1, 16'h1234, 1'b0, 16'h1FFF, 1'b1, 1'b0, 1'b1, 16'h1234, 8'hA5, 8'hC3};
    vecs[9] = '{1'b0, 16'h1234, 1'b0, 16'h1FFF, 1'b0, 1'b0, 1'b0, 16'h1234, 8'hA5, 8'hC3};

    reset = 1'b1;
    a_req = 1'b0; a_addr = 16'h0; b_req = 1'b0; b_addr = 16'h0;
    a3_req = 1'b0; a3_addr = 16'h0; b3_req = 1'b0; b3_addr = 16'h0;
    #1;
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_a_data", a_data, 0);
    check("rst_b_data", b_data, 0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      a_req = vecs[i].a_req; a_addr = vecs[i].a_addr;
      b_req = vecs[i].b_req; b_addr = vecs[i].b_addr;
      step();
      check($sformatf("v%0d_a_ack", i), a_ack, vecs[i].exp_a_ack);
      check($sformatf("v%0d_b_ack", i), b_ack, vecs[i].exp_b_ack);
      check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].exp_rom_addr);
      check($sformatf("v%0d_a_data", i), a_data, vecs[i].exp_a_data);
      check($sformatf("v%0d_b_data", i), b_data, vecs[i].exp_b_data);
    end

    // Both held continuously from reset: grants must alternate A,B,A,B,A,B.
    reset = 1'b1;
    step();
    reset = 1'b0;
    next_a = 16'h0010;
    next_b = 16'h2020;
    a_req = 1'b1; a_addr = next_a;
    b_req = 1'b1; b_addr = next_b;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      exp_b = k[0];
      for (int c = 0; c < 12 && !got; c++) begin
        step();
        check("alt_no_overlap", a_ack & b_ack, 0);
        if (a_ack || b_ack) begin
          got = 1'b1;
          check($sformatf("alt%0d_winner_b", k), b_ack, exp_b);
          if (a_ack) begin
            check($sformatf("alt%0d_a_data", k), a_data, rom_byte(a_addr));
            next_a = next_a + 16'h0101;
            a_addr = next_a;
          end else begin
            check($sformatf("alt%0d_b_data", k), b_data, rom_byte(b_addr));
            next_b = next_b + 16'h0011;
            b_addr = next_b;
          end
          if (k == 5) begin
            a_req = 1'b0;
            b_req = 1'b0;
          end
        end
      end
      check($sformatf("alt%0d_ack_seen", k), got, 1);
    end
    step();
    step();
    check("alt_idle_busy", busy, 0);

    // A drops req right after its grant while B requests.
    a_req = 1'b1; a_addr = 16'h0300;
    step();
    check("drop_grant_busy", busy, 1);
    check("drop_grant_addr", rom_addr, 16'h0300);
    a_req = 1'b0;
    b_req = 1'b1; b_addr = 16'h0200;
    step();
    check("drop_a_ack", a_ack, 1);
    check("drop_a_data", a_data, rom_byte(16'h0300));
    check("drop_b_ack_low", b_ack, 0);
    step();
    check("drop_ack_clear", a_ack, 0);
    step();
    check("drop_b_grant_addr", rom_addr, 16'h0200);
    check("drop_a_data_hold1", a_data, rom_byte(16'h0300));
    step();
    check("drop_b_ack", b_ack, 1);
    check("drop_b_data", b_data, rom_byte(16'h0200));
    check("drop_a_data_hold2", a_data, rom_byte(16'h0300));
    check("drop_no_a_ack", a_ack, 0);
    b_req = 1'b0;
    step();
    check("drop_idle_busy", busy, 0);

    // READ_WAIT=3 instance: ack in the cycle after E3, rom_addr stable E0..E3.
    a3_req = 1'b1; a3_addr = 16'h0100;
    for (int e = 0; e < 3; e++) begin
      step();
      check($sformatf("rw3_e%0d_rom_addr", e), rom_addr3, 16'h0100);
      check($sformatf("rw3_e%0d_ack_low", e), a3_ack, 0);
      check($sformatf("rw3_e%0d_busy", e), busy3, 1);
    end
    step();
    check("rw3_e3_rom_addr", rom_addr3, 16'h0100);
    check("rw3_e3_ack", a3_ack, 1);
    check("rw3_e3_data", a3_data, 8'h7E);
    check("rw3_b_ack_low", b3_ack, 0);
    a3_req = 1'b0;
    step();
    check("rw3_e4_ack_clear", a3_ack, 0);
    check("rw3_e4_busy", busy3, 0);

    // Reset asserted mid-WAIT with A granted.
    a_req = 1'b1; a_addr = 16'h0055;
    step();
    check("rstw_in_wait", busy, 1);
    reset = 1'b1;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_a_ack", a_ack, 0);
    check("rstw_rom_addr", rom_addr, 0);
    check("rstw_a_data", a_data, 0);
    a_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rstw_post%0d_a_ack", c), a_ack, 0);
      check($sformatf("rstw_post%0d_a_data", c), a_data, 0);
      check($sformatf("rstw_post%0d_busy", c), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port read arbiter and sequencer for the shared synchronous BASIC/monitor ROM. Requester A (CPU bus) and requester B (secondary master, e.g. ROM shadow-copy or debug reader) each issue single-byte reads with a req/ack handshake. The block grants one requester at a time with round-robin priority, drives the ROM address, waits the ROM read latency, and returns the byte with a one-cycle ack pulse.

## Interface
- READ_WAIT, 1: posedges between address launch and data capture (ROM registers on negedge → 1); legal 1..15
- ADDR_BITS, 16: address width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- a_req  in  1  requester A read request, held until a_ack
- a_addr  in  ADDR_BITS  requester A address, stable while a_req high
- a_ack  out  1  one-cycle pulse: a_data valid
- a_data  out  8  last byte read for A, held until A's next ack
- b_req, b_addr, b_ack, b_data: same as A for requester B
- rom_addr  out  ADDR_BITS  address to ROM, registered
- rom_data  in  8  ROM read data
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if neither req, stay. If one req, grant it. If both, grant the requester not granted last (last_grant flag). On grant: rom_addr ← granted addr, cnt ← READ_WAIT−1, gnt ← A/B, last_grant ← A/B, → WAIT.
- WAIT: if cnt≠0, cnt ← cnt−1. If cnt=0: capture rom_data into a_data or b_data (granted port only), assert that port's ack, → ACK.
- ACK: ack high for exactly this cycle; req inputs ignored; → IDLE next edge, ack cleared.
- Non-granted request stays pending; it is never dropped and is served on the next IDLE.
- rom_addr holds its value outside grants (no toggling in IDLE).
- Requester releasing req mid-transaction: transaction still completes and acks; requester ignores it. Address change mid-transaction not sampled.
- Reset values: state IDLE, a_ack=b_ack=0, a_data=b_data=0x00, rom_addr=0, busy=0, cnt=0, last_grant=B (A wins first tie).
- Reset asserted mid-transaction: abort immediately, no ack emitted, no data overwritten after reset release.

## Timing
- Edge E0 samples req in IDLE; rom_addr valid after E0; ROM reads on following negedge(s).
- Capture at edge E(READ_WAIT); ack high during the cycle after E(READ_WAIT); busy high from after E0 through the ack cycle.
- Latency req-sampled → ack visible: READ_WAIT cycles; with default, ack in the cycle after E1.
- State returns IDLE at E(READ_WAIT+1); next grant sampled at E(READ_WAIT+2). Throughput: one read per READ_WAIT+2 cycles.
- Requester must drop req (or present a new address for a back-to-back read) by the edge ending its ack cycle; the ACK state guarantees a registered deassert is not misread as a new request.
- a_ack and b_ack never high in the same cycle.

## Test plan
- Reset: assert reset mid-WAIT with A granted → outputs immediately 0, no a_ack after release, busy=0.
- Single A read, ROM model negedge-registered, byte 0x1234=0xA5: a_req at E0 → a_ack high cycle after E1, a_data=0xA5, busy low after ACK.
- Simultaneous a_req (0x0000→0x3C) and b_req (0x1FFF→0xC3) from reset: A acked first with 0x3C, B acked next with 0xC3 exactly 3 cycles later; no ack overlap.
- Both held continuously for 6 transactions → grants alternate A,B,A,B,A,B; each data matches its address.
- READ_WAIT=3: A read of 0x0100=0x7E → a_ack cycle after E3, rom_addr stable 0x0100 E0..E3.
- A drops a_req after E0 while B requests → A transaction still completes (a_ack pulse, a_data updated), then B granted; a_data unchanged during B's read.
